// File: rtl/banner_text_ctrl_if.sv
// banner_text_ctrl_if: pixel/control inputs and slot lookup outputs of the banner sequencer
interface banner_text_ctrl_if #(
  parameter int SLOT_W = 3
);
  logic              show;
  logic              frame_tick;
  logic [9:0]        x;
  logic [9:0]        y;
  logic [31:0]       start_x;
  logic [31:0]       start_y;
  logic [SLOT_W-1:0] slot;
  logic              slot_valid;
  logic              visible;
  logic [1:0]        state;
  logic              done;
  modport master (
    output show, frame_tick, x, y,
    input  start_x, start_y, slot, slot_valid, visible, state, done
  );
  modport slave (
    input  show, frame_tick, x, y,
    output start_x, start_y, slot, slot_valid, visible, state, done
  );
endinterface

// File: rtl/banner_text_ctrl.sv
// banner_text_ctrl: slide/blink/hold sequencer for the text banner with a registered per-pixel glyph slot lookup
module banner_text_ctrl #(
  parameter int unsigned NUM_CHARS     = 8,
  parameter int          SLOT_W        = 3,
  parameter int unsigned CHAR_W        = 26,
  parameter int unsigned CHAR_H        = 40,
  parameter int unsigned PITCH         = 32,
  parameter int unsigned BANNER_X      = 192,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned TARGET_Y      = 200,
  parameter int unsigned SLIDE_STEP    = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input logic               clk,
  input logic               rst_n,
  banner_text_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TGL_LAST = TW'(BLINK_TOGGLES - 1);
  state_t            st;
  logic [31:0]       cur_y;
  logic              visible;
  logic              done;
  logic [BW-1:0]     blink_cnt;
  logic [TW-1:0]     toggles;
  logic [31:0]       x32;
  logic [31:0]       y32;
  logic              in_row;
  logic              hit;
  logic [SLOT_W-1:0] hit_idx;
  logic [31:0]       start_x;
  logic [31:0]       start_y;
  logic [SLOT_W-1:0] slot;
  logic              slot_valid;
  assign x32    = {22'd0, bus.x};
  assign y32    = {22'd0, bus.y};
  assign in_row = y32 >= cur_y && y32 < cur_y + CHAR_H;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cur_y     <= START_Y;
      visible   <= 1'b0;
      blink_cnt <= '0;
      toggles   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // dropping show aborts from any active state, ahead of a coincident frame tick
      if (st != IDLE && !bus.show) begin
        st        <= IDLE;
        cur_y     <= START_Y;
        visible   <= 1'b0;
        blink_cnt <= '0;
        toggles   <= '0;
      end else begin
        case (st)
          IDLE: if (bus.show) begin
            st      <= SLIDE;
            cur_y   <= START_Y;
            visible <= 1'b1;
          end
          SLIDE: if (bus.frame_tick) begin
            if (cur_y + SLIDE_STEP >= TARGET_Y) begin
              st        <= BLINK;
              cur_y     <= TARGET_Y;
              blink_cnt <= '0;
              toggles   <= '0;
              visible   <= 1'b1;
            end else begin
              cur_y <= cur_y + SLIDE_STEP;
            end
          end
          BLINK: if (bus.frame_tick) begin
            if (blink_cnt == BLK_LAST) begin
              blink_cnt <= '0;
              toggles   <= toggles + 1'b1;
              st        <= toggles == TGL_LAST ? HOLD : BLINK;
              visible   <= toggles == TGL_LAST ? 1'b1 : ~visible;
              done      <= toggles == TGL_LAST;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
          HOLD: begin
            visible <= 1'b1;
            cur_y   <= TARGET_Y;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (!hit && in_row && x32 >= BANNER_X + i * PITCH && x32 < BANNER_X + i * PITCH + CHAR_W) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end
  // slot and start_x stay put on a miss so the glyph mux keeps a stable selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_x    <= '0;
      start_y    <= START_Y;
      slot       <= '0;
      slot_valid <= 1'b0;
    end else begin
      start_y    <= cur_y;
      slot_valid <= visible && hit;
      if (hit) begin
        slot    <= hit_idx;
        start_x <= BANNER_X + 32'(hit_idx) * PITCH;
      end
    end
  end
  assign bus.start_x    = start_x;
  assign bus.start_y    = start_y;
  assign bus.slot       = slot;
  assign bus.slot_valid = slot_valid;
  assign bus.visible    = visible;
  assign bus.state      = st;
  assign bus.done       = done;
endmodule

// File: tb/tb_banner_text_ctrl.sv
// tb_banner_text_ctrl: scenario tasks plus randomized run against a frame-count based banner model
module tb_banner_text_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_state, m_y, m_n, e_slot, e_sx, e_sy;
  bit m_vis, m_done, e_valid;
  banner_text_ctrl_if #(.SLOT_W(3)) bus ();
  banner_text_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  task automatic model_reset();
    m_state = 0; m_y = 0; m_n = 0; m_vis = 0; m_done = 0;
    e_slot = 0; e_sx = 0; e_sy = 0; e_valid = 0;
  endtask
  // the model derives visibility from the number of frames spent blinking
  task automatic step(input bit t);
    int xi, yi, rel;
    bit hit;
    xi = int'(bus.x);
    yi = int'(bus.y);
    rel = xi - 192;
    hit = xi >= 192 && rel % 32 < 26 && rel / 32 < 8 && yi >= m_y && yi < m_y + 40;
    if (hit) begin
      e_slot = rel / 32;
      e_sx = 192 + 32 * e_slot;
    end
    e_valid = m_vis && hit;
    e_sy = m_y;
    m_done = 0;
    if (m_state != 0 && !bus.show) begin
      m_state = 0; m_y = 0; m_vis = 0; m_n = 0;
    end else if (m_state == 0) begin
      if (bus.show) begin m_state = 1; m_y = 0; m_vis = 1; end
    end else if (m_state == 1) begin
      if (t) begin
        if (m_y + 8 >= 200) begin m_y = 200; m_state = 2; m_n = 0; m_vis = 1; end
        else m_y = m_y + 8;
      end
    end else if (m_state == 2) begin
      if (t) begin
        m_n++;
        if (m_n == 90) begin m_state = 3; m_vis = 1; m_done = 1; end
        else m_vis = ((m_n / 15) % 2) == 0;
      end
    end
    bus.frame_tick = t;
    @(posedge clk);
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask
  task automatic restart_to_blink();
    bus.show = 1'b0; step(0);
    bus.show = 1'b1; step(0);
    for (int k = 0; k < 25; k++) step(1);
  endtask
  task automatic test_reset();
    checks++; if (bus.state !== 2'd0 || bus.visible !== 1'b0 || bus.start_y !== 32'd0 || bus.slot_valid !== 1'b0 || bus.slot !== 3'd0 || bus.start_x !== 32'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL reset_init: state=%0d vis=%b sy=%0d sv=%b slot=%0d sx=%0d done=%b expected all zero", bus.state, bus.visible, bus.start_y, bus.slot_valid, bus.slot, bus.start_x, bus.done); end
    rst_n = 1'b1;
    model_reset();
    bus.show = 1'b1; step(0);
    step(1); step(1);
    bus.x = 10'd200; bus.y = 10'd20; step(0);
    checks++; if (bus.slot_valid !== 1'b1 || bus.start_y !== 32'd16) begin failures++; $display("FAIL reset_pre: sv=%b sy=%0d expected 1 16", bus.slot_valid, bus.start_y); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0 || bus.visible !== 1'b0 || bus.start_y !== 32'd0 || bus.slot_valid !== 1'b0) begin failures++; $display("FAIL reset_async: state=%0d vis=%b sy=%0d sv=%b expected 0 0 0 0", bus.state, bus.visible, bus.start_y, bus.slot_valid); end
    model_reset();
    bus.show = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_slide();
    int ey;
    bus.x = 10'd0; bus.y = 10'd0;
    bus.show = 1'b1; step(1);
    checks++; if (bus.state !== 2'd1 || bus.visible !== 1'b1) begin failures++; $display("FAIL slide_enter: state=%0d vis=%b expected 1 1", bus.state, bus.visible); end
    for (int k = 1; k <= 25; k++) begin
      step(1);
      checks++; if (bus.state !== (k == 25 ? 2'd2 : 2'd1)) begin failures++; $display("FAIL slide_state k=%0d: state=%0d expected %0d", k, bus.state, k == 25 ? 2 : 1); end
      step(0);
      ey = 8 * k > 200 ? 200 : 8 * k;
      checks++; if (bus.start_y !== 32'(ey)) begin failures++; $display("FAIL slide_y k=%0d: start_y=%0d expected %0d", k, bus.start_y, ey); end
    end
    step(1); step(0);
    checks++; if (bus.start_y !== 32'd200) begin failures++; $display("FAIL slide_clamp: start_y=%0d expected 200", bus.start_y); end
  endtask
  task automatic test_blink();
    for (int k = 1; k <= 88; k++) step(1);
    bus.show = 1'b1;
    for (int k = 1; k < 90; k++) begin
      step(0);
    end
    restart_to_blink();
    for (int k = 1; k <= 90; k++) begin
      step(1);
      if (k < 90) begin
        checks++; if (bus.visible !== (((k / 15) % 2) == 0) || bus.state !== 2'd2 || bus.done !== 1'b0) begin failures++; $display("FAIL blink k=%0d: vis=%b state=%0d done=%b expected %0d 2 0", k, bus.visible, bus.state, bus.done, ((k / 15) % 2) == 0); end
      end
    end
    checks++; if (bus.state !== 2'd3 || bus.visible !== 1'b1 || bus.done !== 1'b1) begin failures++; $display("FAIL blink_end: state=%0d vis=%b done=%b expected 3 1 1", bus.state, bus.visible, bus.done); end
    step(1);
    checks++; if (bus.done !== 1'b0 || bus.state !== 2'd3) begin failures++; $display("FAIL done_pulse: done=%b state=%0d expected 0 3", bus.done, bus.state); end
  endtask
  task automatic test_pixel_map();
    int px[7] = '{261, 218, 261, 416, 441, 442, 192};
    int py[7] = '{210, 210, 240, 239, 200, 200, 200};
    bit ev[7] = '{1, 0, 0, 1, 1, 0, 1};
    int es[7] = '{2, 2, 2, 7, 7, 7, 0};
    for (int i = 0; i < 7; i++) begin
      bus.x = 10'(px[i]); bus.y = 10'(py[i]);
      step(0);
      checks++; if (bus.slot_valid !== ev[i] || bus.slot !== 3'(es[i]) || bus.start_x !== 32'(192 + 32 * es[i]) || bus.start_y !== 32'd200) begin failures++; $display("FAIL pixel x=%0d y=%0d: sv=%b slot=%0d sx=%0d sy=%0d expected %b %0d %0d 200", px[i], py[i], bus.slot_valid, bus.slot, bus.start_x, bus.start_y, ev[i], es[i], 192 + 32 * es[i]); end
    end
  endtask
  task automatic test_blink_mask();
    restart_to_blink();
    bus.x = 10'd200; bus.y = 10'd210;
    step(0);
    checks++; if (bus.slot_valid !== 1'b1 || bus.slot !== 3'd0) begin failures++; $display("FAIL mask_on: sv=%b slot=%0d expected 1 0", bus.slot_valid, bus.slot); end
    for (int k = 0; k < 15; k++) step(1);
    checks++; if (bus.visible !== 1'b0) begin failures++; $display("FAIL mask_vis: vis=%b expected 0", bus.visible); end
    step(0);
    checks++; if (bus.slot_valid !== 1'b0 || bus.slot !== 3'd0 || bus.start_x !== 32'd192) begin failures++; $display("FAIL mask_off: sv=%b slot=%0d sx=%0d expected 0 0 192", bus.slot_valid, bus.slot, bus.start_x); end
  endtask
  task automatic test_abort();
    bus.show = 1'b0; step(1);
    checks++; if (bus.state !== 2'd0 || bus.visible !== 1'b0) begin failures++; $display("FAIL abort: state=%0d vis=%b expected 0 0", bus.state, bus.visible); end
    step(1);
    checks++; if (bus.start_y !== 32'd0 || bus.state !== 2'd0) begin failures++; $display("FAIL abort_y: sy=%0d state=%0d expected 0 0", bus.start_y, bus.state); end
    bus.show = 1'b1; step(0);
    checks++; if (bus.state !== 2'd1 || bus.visible !== 1'b1) begin failures++; $display("FAIL retrigger: state=%0d vis=%b expected 1 1", bus.state, bus.visible); end
    step(1); step(0);
    checks++; if (bus.start_y !== 32'd8) begin failures++; $display("FAIL retrigger_y: sy=%0d expected 8", bus.start_y); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.show = ($urandom % 400) != 0;
      bus.x = 10'($urandom_range(150, 500));
      bus.y = 10'((m_y >= 5 ? m_y - 5 : 0) + int'($urandom_range(0, 50)));
      step(($urandom % 2) == 0);
      checks++; if (bus.state !== 2'(m_state) || bus.visible !== m_vis || bus.done !== m_done) begin failures++; $display("FAIL rand_fsm c=%0d: state=%0d vis=%b done=%b expected %0d %b %b", c, bus.state, bus.visible, bus.done, m_state, m_vis, m_done); end
      checks++; if (bus.slot_valid !== e_valid || bus.slot !== 3'(e_slot) || bus.start_x !== 32'(e_sx) || bus.start_y !== 32'(e_sy)) begin failures++; $display("FAIL rand_pix c=%0d: sv=%b slot=%0d sx=%0d sy=%0d expected %b %0d %0d %0d", c, bus.slot_valid, bus.slot, bus.start_x, bus.start_y, e_valid, e_slot, e_sx, e_sy); end
    end
  endtask
  initial begin
    bus.show = 1'b0; bus.frame_tick = 1'b0; bus.x = 10'd0; bus.y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_slide();
    test_blink();
    test_pixel_map();
    test_blink_mask();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
